// File: rtl/icache_assoc_if.sv
// icache_assoc_if: fetch-port and arbiter-port signals of the instruction cache.
interface icache_assoc_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );
  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_assoc.sv
// icache_assoc: read-only 1/2-way LRU instruction cache with multi-word block fill and flush.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_assoc #(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2
) (
  input logic CLK,
  input logic RST,
  icache_assoc_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int IW = $clog2(SETS);
  localparam int OW = $clog2(BLKWORDS);
  localparam int CW = (OW > 0) ? OW : 1;
  localparam int TW = 30 - OW - IW;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] base_q, base_d;
  logic vic_q, vic_d;
  logic [31:0] data_q [WAYS][SETS][BLKWORDS];
  logic [TW-1:0] tag_q [WAYS][SETS];
  logic [WAYS-1:0][SETS-1:0] valid_q;
  logic [SETS-1:0] lru_q;
  logic [IW-1:0] idx, fidx;
  logic [TW-1:0] tag;
  logic [CW-1:0] off;
  logic [1:0] hitw;
  logic hit_way, miss, accept, last, vic;
  assign idx  = bus.imemaddr[2+OW +: IW];
  assign tag  = bus.imemaddr[31 -: TW];
  assign off  = (BLKWORDS > 1) ? bus.imemaddr[2 +: CW] : '0;
  assign fidx = base_q[2+OW +: IW];
  always_comb begin
    hitw = '0;
    for (int w = 0; w < WAYS; w++) hitw[w] = valid_q[w][idx] && (tag_q[w][idx] == tag);
  end
  assign hit_way      = hitw[1];
  assign bus.ihit     = (state_q == IDLE) && bus.imemREN && !bus.flush && (|hitw);
  assign miss         = (state_q == IDLE) && bus.imemREN && !bus.flush && !(|hitw);
  assign bus.imemload = bus.ihit ? data_q[hit_way][idx][off] : '0;
  assign bus.iREN     = (state_q == FILL) && !bus.flush;
  assign bus.iaddr    = bus.iREN ? base_q + (32'(cnt_q) << 2) : '0;
  assign accept       = bus.iREN && !bus.iwait;
  assign last         = accept && (cnt_q == CW'(BLKWORDS - 1));
  // Prefer an empty way (way0 first) before evicting the least recently used one.
  assign vic = (WAYS == 1) ? 1'b0 : !valid_q[0][idx] ? 1'b0 :
               !valid_q[WAYS-1][idx] ? 1'b1 : lru_q[idx];
  always_comb begin
    state_d = bus.flush ? IDLE : miss ? FILL : last ? IDLE : state_q;
    cnt_d   = (bus.flush || last) ? '0 : accept ? CW'(cnt_q + 1'b1) : cnt_q;
    base_d  = miss ? (bus.imemaddr & ~32'(BLKWORDS * 4 - 1)) : base_q;
    vic_d   = miss ? vic : vic_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (bus.flush) begin
        valid_q <= '0;
        lru_q   <= '0;
      end else begin
        if (last) valid_q[vic_q][fidx] <= 1'b1;
        if (WAYS == 2 && bus.ihit) lru_q[idx] <= ~hit_way;
        if (WAYS == 2 && last) lru_q[fidx] <= ~vic_q;
      end
    end
  end
  // Payload storage is never reset; valid bits alone qualify it.
  always_ff @(posedge CLK) begin
    base_q <= base_d;
    vic_q  <= vic_d;
    if (accept) data_q[vic_q][fidx][cnt_q] <= bus.iload;
    if (last) tag_q[vic_q][fidx] <= base_q[31 -: TW];
  end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      hit_count  <= hit_count + 32'(bus.ihit);
      miss_count <= miss_count + 32'(miss);
    end
  end
`endif
endmodule
